conv_seq: RTL and testbench

Sequencer directly upstream of the memory control unit (MCU) in the 2D-convolution datapath. It turns host-side commands and the pixel byte stream into the MCU's control inputs:
- write/read addresses;
- start-of-processing, end-of-processing and change-block pulses;
- a registered pixel byte with a write strobe.

It runs the load → convolve → write-back cycle for one column block at a time until the host flags the last block.

---
 rtl/conv_seq_if.sv | 30 +++
 rtl/conv_seq.sv | 164 ++++++++++++++++
 tb/tb_conv_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_if.sv
// Host/MCU-facing signal bundle of the convolution sequencer.
// The slave modport is the sequencer side; the master modport is the host/MCU side.
interface conv_seq_if #(
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_ADDR   = 10
);
  logic                   i_start;
  logic [BITS_ADDR-1:0]   i_imgLen;
  logic                   i_valid;
  logic [BITS_IMAGEN-1:0] i_Data;
  logic                   i_lastBlk;
  logic [BITS_IMAGEN-1:0] o_Data;
  logic                   o_we;
  logic [BITS_ADDR-1:0]   o_WAddr;
  logic [BITS_ADDR-1:0]   o_RAddr;
  logic                   o_sop;
  logic                   o_eop;
  logic                   o_chblk;
  logic                   o_busy;

  modport master (
    output i_start, i_imgLen, i_valid, i_Data, i_lastBlk,
    input  o_Data, o_we, o_WAddr, o_RAddr, o_sop, o_eop, o_chblk, o_busy
  );

  modport slave (
    input  i_start, i_imgLen, i_valid, i_Data, i_lastBlk,
    output o_Data, o_we, o_WAddr, o_RAddr, o_sop, o_eop, o_chblk, o_busy
  );
endinterface

// File: rtl/conv_seq.sv
// Sequencer feeding the 2D-convolution memory control unit.
// It runs load -> convolve -> write-back per column block until the host flags the last one.
module conv_seq #(
  parameter int N           = 16,
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_ADDR   = 10,
  parameter int LATENCY     = 2
) (
  input logic      clk,
  input logic      rst,
  conv_seq_if.slave bus
);

  localparam int FW = $clog2(LATENCY) + 1;

  if (LATENCY < 1 || N < 1) begin : g_bad_param
    $error("conv_seq: LATENCY and N must both be at least 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [BITS_ADDR-1:0]   len_q, len_d;
  logic [BITS_ADDR-1:0]   wcnt_q, wcnt_d;
  logic [BITS_ADDR-1:0]   rcnt_q, rcnt_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic [BITS_IMAGEN-1:0] data_q, data_d;
  logic                   we_q, we_d;
  logic [BITS_ADDR-1:0]   waddr_q, waddr_d;
  logic [BITS_ADDR-1:0]   raddr_q, raddr_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic                   chblk_q, chblk_d;
  logic                   busy_q, busy_d;
  logic                   issue_d;
  logic [LATENCY-1:0]     wbV_q;
  logic [BITS_ADDR-1:0]   wbA_q [LATENCY];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    fcnt_d  = fcnt_q;
    data_d  = data_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    chblk_d = 1'b0;
    issue_d = 1'b0;

    // The write-back pipe is only ever occupied during RUN/FLUSH, so it never collides with LOAD writes.
    if (wbV_q[LATENCY-1]) begin
      we_d    = 1'b1;
      waddr_d = wbA_q[LATENCY-1];
    end

    case (state_q)
      IDLE: begin
        if (bus.i_start && bus.i_imgLen != '0) begin
          len_d   = bus.i_imgLen;
          wcnt_d  = '0;
          sop_d   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.i_valid) begin
          we_d    = 1'b1;
          waddr_d = wcnt_q;
          data_d  = bus.i_Data;
          if (wcnt_q == len_q - 1'b1) begin
            wcnt_d  = '0;
            rcnt_d  = '0;
            state_d = RUN;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        raddr_d = rcnt_q;
        issue_d = 1'b1;
        if (rcnt_q == len_q - 1'b1) begin
          rcnt_d  = '0;
          fcnt_d  = '0;
          state_d = FLUSH;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (fcnt_q == FW'(LATENCY - 1)) begin
          if (bus.i_lastBlk) begin
            eop_d   = 1'b1;
            state_d = IDLE;
          end else begin
            chblk_d = 1'b1;
            wcnt_d  = '0;
            state_d = LOAD;
          end
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      fcnt_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      chblk_q <= 1'b0;
      busy_q  <= 1'b0;
      wbV_q   <= '0;
      for (int i = 0; i < LATENCY; i++) wbA_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      fcnt_q  <= fcnt_d;
      data_q  <= data_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      chblk_q <= chblk_d;
      busy_q  <= busy_d;
      // Stage 0 lines up with the presented read address; the last stage feeds the strobe register.
      wbV_q[0] <= issue_d;
      wbA_q[0] <= rcnt_q;
      for (int i = 1; i < LATENCY; i++) begin
        wbV_q[i] <= wbV_q[i-1];
        wbA_q[i] <= wbA_q[i-1];
      end
    end
  end

  assign bus.o_Data  = data_q;
  assign bus.o_we    = we_q;
  assign bus.o_WAddr = waddr_q;
  assign bus.o_RAddr = raddr_q;
  assign bus.o_sop   = sop_q;
  assign bus.o_eop   = eop_q;
  assign bus.o_chblk = chblk_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_conv_seq.sv
// Randomized scoreboard bench for conv_seq: the driver queues each frame's expected
// event stream, a negedge monitor pops and compares whatever the DUT presents.
module tb_conv_seq;
  localparam int BI  = 8;
  localparam int BA  = 10;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_seq_if #(.BITS_IMAGEN(BI), .BITS_ADDR(BA)) bus ();

  conv_seq #(.N(16), .BITS_IMAGEN(BI), .BITS_ADDR(BA), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum {EV_SOP, EV_WR, EV_WB, EV_CHBLK, EV_EOP} evKind_t;
  typedef struct {
    evKind_t kind;
    int      addr;
    int      data;
  } ev_t;

  ev_t        expQ[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  bit         monOff = 1'b1;
  bit         inFrame = 1'b0;
  int         rH[0:3];
  logic [7:0] dat [0:2][0:1022];

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic popExpect(input string name, output ev_t e);
    e = '{kind: EV_SOP, addr: -1, data: -1};
    checkOutput({name, "Expected"}, int'(expQ.size() > 0), 1);
    if (expQ.size() > 0) e = expQ.pop_front();
  endtask

  task automatic monitorCycle();
    ev_t e;
    int  nPulse;
    nPulse = int'(bus.o_sop) + int'(bus.o_eop) + int'(bus.o_chblk);
    if (nPulse > 0 || bus.o_we) begin
      checkOutput("pulseOverlap", int'(nPulse <= 1), 1);
      checkOutput("weWithSop", int'(bus.o_we && bus.o_sop), 0);
    end
    if (bus.o_sop) begin
      popExpect("sop", e);
      checkOutput("sopKind", int'(e.kind), int'(EV_SOP));
      inFrame = 1'b1;
    end
    if (bus.o_we) begin
      popExpect("write", e);
      checkOutput("writeKind", int'(e.kind == EV_WR || e.kind == EV_WB), 1);
      checkOutput("writeAddr", int'(bus.o_WAddr), e.addr);
      checkOutput("writeData", int'(bus.o_Data), e.data);
      if (e.kind == EV_WB) begin
        checkOutput("wbLatency", rH[LAT-1], e.addr);
        if (e.addr > 0) checkOutput("readContig", rH[LAT], e.addr - 1);
      end
    end
    if (bus.o_chblk || bus.o_eop) begin
      popExpect("blockEnd", e);
      checkOutput("blockEndKind", int'(e.kind), bus.o_eop ? int'(EV_EOP) : int'(EV_CHBLK));
      checkOutput("lastWbAtEnd", int'(bus.o_we), 1);
      checkOutput("lastWbAddr", int'(bus.o_WAddr), e.addr);
      if (bus.o_eop) inFrame = 1'b0;
    end
    checkOutput("busy", int'(bus.o_busy), int'(inFrame));
    for (int k = 3; k > 0; k--) rH[k] = rH[k-1];
    rH[0] = int'(bus.o_RAddr);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!monOff) monitorCycle();
    end
  end

  // Control inputs that the sequencer must ignore outside IDLE.
  task automatic scrambleControl(input bit junk);
    if (junk) begin
      bus.i_start  = 1'($urandom_range(0, 1));
      bus.i_imgLen = BA'($urandom);
    end else begin
      bus.i_start = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int len, input int nBlk, input bit fullRate,
                               input bit fixedBytes, input bit junk);
    int t0;
    int waitCyc;
    for (int b = 0; b < nBlk; b++)
      for (int i = 0; i < len; i++)
        dat[b][i] = fixedBytes ? 8'((i + 1) * 17) : 8'($urandom_range(0, 255));
    expQ.push_back('{kind: EV_SOP, addr: 0, data: 0});
    for (int b = 0; b < nBlk; b++) begin
      for (int i = 0; i < len; i++) expQ.push_back('{kind: EV_WR, addr: i, data: int'(dat[b][i])});
      for (int i = 0; i < len; i++) expQ.push_back('{kind: EV_WB, addr: i, data: int'(dat[b][len-1])});
      expQ.push_back('{kind: (b == nBlk - 1) ? EV_EOP : EV_CHBLK, addr: len - 1, data: 0});
    end
    bus.i_start  = 1'b1;
    bus.i_imgLen = BA'(len);
    tick();
    bus.i_start = 1'b0;
    t0 = cyc;
    for (int b = 0; b < nBlk; b++) begin
      bus.i_lastBlk = (b == nBlk - 1);
      for (int i = 0; i < len; i++) begin
        if (!fullRate) begin
          while ($urandom_range(0, 2) == 0) begin
            bus.i_valid = 1'b0;
            bus.i_Data  = 8'($urandom);
            scrambleControl(junk);
            tick();
          end
        end
        bus.i_valid = 1'b1;
        bus.i_Data  = dat[b][i];
        scrambleControl(junk);
        tick();
      end
      waitCyc = 0;
      while (!(bus.o_chblk || bus.o_eop) && waitCyc < len + LAT + 10) begin
        bus.i_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.i_Data  = 8'($urandom);
        scrambleControl(junk);
        tick();
        waitCyc++;
      end
      bus.i_valid = 1'b0;
      bus.i_start = 1'b0;
      checkOutput("blockEndSeen", int'(bus.o_chblk || bus.o_eop), 1);
      if (!(bus.o_chblk || bus.o_eop)) break;
    end
    bus.i_lastBlk = 1'b0;
    if (fullRate && nBlk == 1) checkOutput("frameLength", cyc - t0, 2 * len + LAT);
    tick();
    tick();
  endtask

  initial begin
    bus.i_start   = 1'b0;
    bus.i_imgLen  = '0;
    bus.i_valid   = 1'b0;
    bus.i_Data    = '0;
    bus.i_lastBlk = 1'b0;
    for (int k = 0; k < 4; k++) rH[k] = 0;
    repeat (3) tick();
    checkOutput("rstBusy", int'(bus.o_busy), 0);
    checkOutput("rstWe", int'(bus.o_we), 0);
    checkOutput("rstSop", int'(bus.o_sop), 0);
    checkOutput("rstData", int'(bus.o_Data), 0);
    checkOutput("rstRAddr", int'(bus.o_RAddr), 0);
    rst = 1'b1;
    tick();
    monOff = 1'b0;

    $display("[TB] zero-length start in IDLE");
    bus.i_start  = 1'b1;
    bus.i_imgLen = '0;
    tick();
    bus.i_start = 1'b0;
    tick();
    checkOutput("zeroLenBusy", int'(bus.o_busy), 0);

    $display("[TB] single block, len 4, fixed bytes with gaps");
    applyStimulus(4, 1, 1'b0, 1'b1, 1'b0);
    $display("[TB] two blocks, len 4");
    applyStimulus(4, 2, 1'b0, 1'b1, 1'b0);
    $display("[TB] ignored start/valid outside their states");
    applyStimulus(5, 2, 1'b0, 1'b0, 1'b1);
    $display("[TB] minimum length");
    applyStimulus(1, 1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1, 3, 1'b0, 1'b0, 1'b1);
    $display("[TB] maximum length");
    applyStimulus(1023, 1, 1'b1, 1'b0, 1'b0);

    $display("[TB] asynchronous reset mid-RUN");
    monOff = 1'b1;
    bus.i_start  = 1'b1;
    bus.i_imgLen = BA'(4);
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_valid = 1'b1;
      bus.i_Data  = 8'($urandom_range(1, 255));
      tick();
    end
    bus.i_valid = 1'b0;
    tick();
    tick();
    checkOutput("preResetBusy", int'(bus.o_busy), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("asyncBusy", int'(bus.o_busy), 0);
    checkOutput("asyncWe", int'(bus.o_we), 0);
    checkOutput("asyncData", int'(bus.o_Data), 0);
    checkOutput("asyncWAddr", int'(bus.o_WAddr), 0);
    checkOutput("asyncRAddr", int'(bus.o_RAddr), 0);
    checkOutput("asyncPulses", int'(bus.o_sop | bus.o_eop | bus.o_chblk), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("postResetBusy", int'(bus.o_busy), 0);
    checkOutput("postResetSop", int'(bus.o_sop), 0);
    expQ.delete();
    inFrame = 1'b0;
    for (int k = 0; k < 4; k++) rH[k] = 0;
    monOff = 1'b0;
    applyStimulus(4, 1, 1'b1, 1'b0, 1'b0);

    $display("[TB] random frames");
    repeat (8) applyStimulus($urandom_range(1, 20), $urandom_range(1, 3),
                             1'($urandom_range(0, 1)), 1'b0, 1'b1);

    repeat (4) tick();
    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
